// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared encodings for the register-file/ALU sequencing controller
package reg_seq_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'h0,
    OP_MOV  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOT  = 4'h7
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3
  } state_e;

  typedef enum logic [1:0] {
    CL_LOAD,
    CL_MOV,
    CL_ALU,
    CL_ILL
  } op_class_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;

  localparam logic [1:0] WSEL_IMM = 2'd0;
  localparam logic [1:0] WSEL_Q0  = 2'd1;
  localparam logic [1:0] WSEL_G   = 2'd2;

  localparam int OP_LSB = 6;
  localparam int OP_W   = 4;
  localparam int RX_LSB = 4;
  localparam int RY_LSB = 2;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: classifies the held instruction and extracts its register fields
module instr_decode
  import reg_seq_pkg::*;
#(
  parameter int DW = 10,
  parameter int AW = 2
) (
  input  logic [DW-1:0] ir,
  output op_class_e     op_class,
  output logic [2:0]    alu_op,
  output logic          uses_ry,
  output logic [AW-1:0] rx,
  output logic [AW-1:0] ry
);

  logic [OP_W-1:0] opc;
  logic            unused_bits;

  assign opc         = ir[OP_LSB +: OP_W];
  assign rx          = ir[RX_LSB +: AW];
  assign ry          = ir[RY_LSB +: AW];
  assign unused_bits = ^ir[RY_LSB-1:0];

  // ALU opcodes 2..7 map onto ALU_OP 0..5 in the same order
  always_comb begin
    op_class = opc[3] ? CL_ILL : (opc == OP_LOAD) ? CL_LOAD : (opc == OP_MOV) ? CL_MOV : CL_ALU;
    alu_op   = (op_class == CL_ALU) ? opc[2:0] - 3'd2 : ALU_ADD;
    uses_ry  = (op_class == CL_MOV) || (op_class == CL_ALU && opc != OP_NOT);
  end

endmodule

// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: multi-cycle controller sequencing a 4-entry register file and ALU
module reg_seq_ctrl
  import reg_seq_pkg::*;
#(
  parameter int DW = 10,
  parameter int AW = 2
) (
  input  logic          CLKb,
  input  logic          RSTb,
  input  logic [DW-1:0] INSTR,
  input  logic [DW-1:0] DIN,
  input  logic          IVALID,
  output logic          IREADY,
  output logic          ENW,
  output logic [AW-1:0] WRA,
  output logic          ENR0,
  output logic [AW-1:0] RDA0,
  output logic          ENR1,
  output logic [AW-1:0] RDA1,
  output logic [2:0]    ALU_OP,
  output logic          LD_A,
  output logic          LD_G,
  output logic [1:0]    WSEL,
  output logic [DW-1:0] IMM,
  output logic          DONE,
  output logic          ILLEGAL
);

  state_e          state_q, state_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   imm_q, imm_d;
  op_class_e       op_class;
  logic [2:0]      alu_op;
  logic            uses_ry;
  logic [AW-1:0]   rx, ry;

  instr_decode #(.DW(DW), .AW(AW)) u_dec (
    .ir       (ir_q),
    .op_class (op_class),
    .alu_op   (alu_op),
    .uses_ry  (uses_ry),
    .rx       (rx),
    .ry       (ry)
  );

  assign IMM = imm_q;

  // state, instruction and immediate registers; reset aborts any instruction in flight
  always_ff @(posedge CLKb) begin
    if (!RSTb) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  // next state and datapath controls, decoded from registered state and IR only
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    IREADY  = 1'b0;
    ENW     = 1'b0;
    WRA     = '0;
    ENR0    = 1'b0;
    RDA0    = '0;
    ENR1    = 1'b0;
    RDA1    = '0;
    ALU_OP  = ALU_ADD;
    LD_A    = 1'b0;
    LD_G    = 1'b0;
    WSEL    = WSEL_IMM;
    DONE    = 1'b0;
    ILLEGAL = 1'b0;
    case (state_q)
      S_IDLE: begin
        IREADY = 1'b1;
        if (IVALID) begin
          state_d = S_T1;
          ir_d    = INSTR;
          imm_d   = DIN;
        end
      end
      S_T1: begin
        state_d = (op_class == CL_ALU) ? S_T2 : S_IDLE;
        case (op_class)
          CL_LOAD: begin
            ENW  = 1'b1;
            WRA  = rx;
            WSEL = WSEL_IMM;
            DONE = 1'b1;
          end
          CL_MOV: begin
            ENR0 = 1'b1;
            RDA0 = ry;
            ENW  = 1'b1;
            WRA  = rx;
            WSEL = WSEL_Q0;
            DONE = 1'b1;
          end
          CL_ALU: begin
            ENR0 = 1'b1;
            RDA0 = rx;
            LD_A = 1'b1;
          end
          CL_ILL: ILLEGAL = 1'b1;
        endcase
      end
      S_T2: begin
        state_d = S_T3;
        ALU_OP  = alu_op;
        LD_G    = 1'b1;
        ENR1    = uses_ry;
        RDA1    = uses_ry ? ry : '0;
      end
      S_T3: begin
        state_d = S_IDLE;
        ENW     = 1'b1;
        WRA     = rx;
        WSEL    = WSEL_G;
        DONE    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/reg_seq_ctrl.md
Name: reg_seq_ctrl

Overview:
- Multi-cycle control FSM that sequences the 4-entry, 10-bit two-read/one-write register file and the ALU of the processor datapath.
- Accepts one instruction at a time through a valid/ready handshake.
- Decodes each instruction and drives the register-file read/write enables and addresses, the ALU operation, the operand/result latch strobes and the write-data select.
- Signals completion of each instruction.

Parameters:
- DW, 10: datapath and instruction width.
- AW, 2: register address width (2**AW = 4 registers).

Ports:
- CLKb  in  1  system clock; all state changes on rising edge.
- RSTb  in  1  reset, active-low, synchronous.
- INSTR  in  DW  instruction; [9:6] opcode, [5:4] Rx (destination / first source), [3:2] Ry (second source), [1:0] ignored.
- DIN  in  DW  external load data, sampled with INSTR.
- IVALID  in  1  INSTR/DIN valid.
- IREADY  out  1  controller can accept an instruction.
- ENW  out  1  register-file write enable.
- WRA  out  AW  register-file write address.
- ENR0  out  1  read-port-0 enable.
- RDA0  out  AW  read-port-0 address.
- ENR1  out  1  read-port-1 enable.
- RDA1  out  AW  read-port-1 address.
- ALU_OP  out  3  ALU operation code.
- LD_A  out  1  load ALU operand register A from Q0.
- LD_G  out  1  load ALU result register G.
- WSEL  out  2  write-data select: 0 = IMM, 1 = Q0, 2 = G.
- IMM  out  DW  DIN latched at acceptance.
- DONE  out  1  one-cycle pulse in the final cycle of a legal instruction.
- ILLEGAL  out  1  one-cycle pulse for an undefined opcode.

Behaviour:
- Reset:
  - RSTb low at a rising edge forces state IDLE and clears IR and IMM to 0.
  - All enables, strobes, DONE and ILLEGAL are 0 in the cycle after the edge.
  - WRA/RDA0/RDA1/ALU_OP/WSEL are 0.
  - IREADY is 1 once RSTb is high.
  - Reset mid-instruction aborts it; no write is issued afterwards.
- Outputs are decoded combinationally from the registered state and IR only. There are no combinational paths from any input to any output.
- Opcodes:
  - 0000 LOAD: Rx <= DIN.
  - 0001 MOV: Rx <= Ry.
  - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR: Rx <= Rx op Ry.
  - 0111 NOT: Rx <= ~Rx.
  - 1000-1111: illegal.
- ALU_OP values: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOT 5.
  - Arithmetic is modulo 2**DW; carry/borrow are discarded (controller-independent).
- States: IDLE, T1, T2, T3.
- IDLE:
  - IREADY = 1.
  - When IVALID && IREADY at an edge: IR <= INSTR, IMM <= DIN, go to T1. Otherwise stay in IDLE.
- T1 (IREADY = 0 from T1 through T3):
  - LOAD: ENW = 1, WRA = Rx, WSEL = 0, DONE = 1; next state IDLE.
  - MOV: ENR0 = 1, RDA0 = Ry, ENW = 1, WRA = Rx, WSEL = 1, DONE = 1; next state IDLE. Rx == Ry is legal.
  - ALU ops: ENR0 = 1, RDA0 = Rx, LD_A = 1; next state T2.
  - Illegal: ILLEGAL = 1, no enables; next state IDLE.
- T2:
  - ALU_OP = decoded op, LD_G = 1.
  - For two-operand ops: ENR1 = 1, RDA1 = Ry. For NOT: ENR1 = 0.
  - Next state T3.
- T3: ENW = 1, WRA = Rx, WSEL = 2, DONE = 1; next state IDLE.
- Latency:
  - LOAD, MOV and illegal: 1 cycle after acceptance.
  - ALU ops: 3 cycles after acceptance.
  - Next acceptance is possible in the cycle after DONE/ILLEGAL.
  - Peak throughput: one instruction per 2 cycles (LOAD/MOV), one per 4 cycles (ALU).
- An IVALID asserted while busy is ignored; the source must hold INSTR/DIN until IREADY is high.
- Same-register operations (e.g. ADD R1,R1) need no special handling: read-before-write ordering is guaranteed by the separate T1/T2/T3 cycles.
- Unused address outputs are driven to 0 when their enable is 0.

Decomposition:
- Shared package reg_seq_pkg holds:
  - opcode enum (4 bits);
  - state enum;
  - ALU_OP codes;
  - WSEL codes;
  - INSTR field bit positions.
- One sub-module, instr_decode (combinational): maps IR to opcode class (LOAD/MOV/ALU/ILLEGAL), ALU_OP, uses_ry and Rx/Ry fields.

Test Plan:
- Reset: hold RSTb = 0 for 2 edges, mid-ADD at T2 -> next cycle state IDLE, ENW = 0, IREADY = 1, IMM = 0; no write ever occurs for the aborted ADD.
- LOAD R2 with DIN = 10'h2A5: INSTR = 10'b0000_10_00_00 -> one cycle later ENW = 1, WRA = 2, WSEL = 0, IMM = 10'h2A5, DONE = 1; IREADY returns the next cycle.
- ADD R1,R3 (INSTR = 10'b0010_01_11_00):
  - T1: ENR0 = 1, RDA0 = 1, LD_A = 1.
  - T2: ENR1 = 1, RDA1 = 3, ALU_OP = 0, LD_G = 1.
  - T3: ENW = 1, WRA = 1, WSEL = 2, DONE = 1.
  - With the datapath attached, R1 = 10'h3FF and R3 = 2 give R1 = 10'h001 (wrap).
- NOT R0 -> T2 asserts LD_G = 1, ALU_OP = 5, ENR1 = 0; T3 writes WRA = 0.
- Illegal opcode 1011 -> ILLEGAL pulses one cycle after acceptance, ENW/ENR0/ENR1 stay 0, DONE = 0.
- Back-to-back: IVALID held high with MOV R0,R1 then SUB R2,R2:
  - second instruction accepted in the cycle after MOV's DONE;
  - IVALID pulses during T1-T3 are ignored;
  - R2 = 0 at the end.
